// File: rtl/johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// johnson_seq_ctrl
//   Run controller for an N-bit Johnson (twisted-ring) pattern. A run starts
//   from IDLE, advances the pattern one position every DIV clock cycles
//   (forward or reverse, chosen at each step), and either finishes after a
//   latched number of steps or runs freely until stopped. The pattern can be
//   preloaded in IDLE; an illegal preload is replaced by zero and flagged.
//
// Parameters
//   N    Johnson register width (2..16)
//   DIV  clock cycles per step (1..255)
//
// Ports
//   iClk      in   clock, all state changes on the rising edge
//   iReset    in   synchronous active-high reset
//   iStart    in   pulse, starts a run from IDLE
//   iStop     in   pulse, aborts a run (RUN or HOLD)
//   iHold     in   level, freezes a run while high
//   iDir      in   0 = forward, 1 = reverse, sampled at each step
//   iSteps    in   step count latched at start, 0 = free-run
//   iLoad     in   pulse, preloads iPattern in IDLE
//   iPattern  in   preload value
//   oSalida   out  current Johnson pattern
//   oIndex    out  position of oSalida in the 2N-state sequence
//   oBusy     out  high in RUN and HOLD
//   oDone     out  high for the single cycle spent in DONE
//   oError    out  sticky illegal-preload flag, cleared only by reset
// -----------------------------------------------------------------------------
module johnson_seq_ctrl #(
  parameter int N   = 4,
  parameter int DIV = 1
) (
  input  logic                      iClk,
  input  logic                      iReset,
  input  logic                      iStart,
  input  logic                      iStop,
  input  logic                      iHold,
  input  logic                      iDir,
  input  logic [7:0]                iSteps,
  input  logic                      iLoad,
  input  logic [N-1:0]              iPattern,
  output logic [N-1:0]              oSalida,
  output logic [$clog2(2*N)-1:0]    oIndex,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oError
);

  localparam int IW = $clog2(2*N);
  localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state_q;
  logic [N-1:0] pat_q;
  logic [7:0]   presc_q;
  logic [7:0]   rem_q;
  logic         free_q;     // run was started with iSteps = 0
  logic         busy_q;
  logic         done_q;
  logic         error_q;

  logic [N-1:0] step_pat_d;
  logic         step_evt_s;

  // A Johnson code has at most one boundary between adjacent differing bits.
  function automatic logic is_legal(input logic [N-1:0] p);
    int edges;
    edges = 0;
    for (int i = 0; i < N - 1; i++) begin
      edges = edges + int'(p[i] ^ p[i+1]);
    end
    return (edges <= 1);
  endfunction

  // Position in the sequence: the filling half has bit 0 set and the index
  // equals the number of ones; the draining half counts down from 2N.
  function automatic logic [IW-1:0] johnson_index(input logic [N-1:0] p);
    int ones;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      ones = ones + int'(p[i]);
    end
    if (p == '0) begin
      return '0;
    end else if (p[0]) begin
      return IW'(ones);
    end else begin
      return IW'(2 * N - ones);
    end
  endfunction

  assign step_evt_s = (presc_q == PRESC_LAST);

  // Candidate next pattern for the current direction.
  always_comb begin
    if (iDir) begin
      step_pat_d = {~pat_q[0], pat_q[N-1:1]};
    end else begin
      step_pat_d = {pat_q[N-2:0], ~pat_q[N-1]};
    end
  end

  // Run-control FSM with prescaler, step counter and registered flags.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      presc_q <= 8'd0;
      rem_q   <= 8'd0;
      free_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          // Load wins over a coincident start; stop is meaningless here.
          if (iLoad) begin
            if (is_legal(iPattern)) begin
              pat_q <= iPattern;
            end else begin
              pat_q   <= '0;
              error_q <= 1'b1;
            end
          end else if (iStart) begin
            state_q <= S_RUN;
            presc_q <= 8'd0;
            rem_q   <= iSteps;
            free_q  <= (iSteps == 8'd0);
            busy_q  <= 1'b1;
          end
        end

        S_RUN: begin
          // Stop beats hold and a coincident step. Hold freezes the run on
          // the very cycle it is seen, so the prescaler does not count then.
          if (iStop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (iHold) begin
            state_q <= S_HOLD;
          end else if (step_evt_s) begin
            pat_q   <= step_pat_d;
            presc_q <= 8'd0;
            if (!free_q) begin
              rem_q <= rem_q - 8'd1;
              if (rem_q == 8'd1) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end else begin
            presc_q <= presc_q + 8'd1;
          end
        end

        S_HOLD: begin
          if (iStop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (!iHold) begin
            state_q <= S_RUN;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oSalida = pat_q;
  assign oIndex  = johnson_index(pat_q);
  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oError  = error_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl (N=4, DIV=2). Stimulus pushes every
// expected output change (absolute clock edge plus output values) into a
// queue; the monitor pops one entry whenever the DUT outputs change.
module tb_johnson_seq_ctrl;

  logic       clk = 1'b0;
  logic       iReset = 1'b1;
  logic       iStart = 1'b0;
  logic       iStop = 1'b0;
  logic       iHold = 1'b0;
  logic       iDir = 1'b0;
  logic [7:0] iSteps = 8'd0;
  logic       iLoad = 1'b0;
  logic [3:0] iPattern = 4'd0;
  logic [3:0] oSalida;
  logic [2:0] oIndex;
  logic       oBusy;
  logic       oDone;
  logic       oError;

  johnson_seq_ctrl #(.N(4), .DIV(2)) dut (
    .iClk(clk), .iReset(iReset), .iStart(iStart), .iStop(iStop),
    .iHold(iHold), .iDir(iDir), .iSteps(iSteps), .iLoad(iLoad),
    .iPattern(iPattern), .oSalida(oSalida), .oIndex(oIndex),
    .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         cyc;
    logic [9:0] val;  // {salida, index, busy, done, error}
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       mon_en = 1'b0;
  logic [9:0] prev = 10'd0;

  task automatic push(input string nm, input int c, input logic [3:0] s,
                      input logic [2:0] ix, input logic b, input logic d,
                      input logic e);
    exp_t x;
    x.name = nm;
    x.cyc  = c;
    x.val  = {s, ix, b, d, e};
    exp_q.push_back(x);
  endtask

  // Monitor: every output change is matched against the next expectation.
  always @(negedge clk) begin
    logic [9:0] cur;
    exp_t       x;
    if (mon_en) begin
      cur = {oSalida, oIndex, oBusy, oDone, oError};
      if (cur !== prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change edge=%0d got=%b", cyc, cur);
        end else begin
          x = exp_q.pop_front();
          if (cur !== x.val || cyc != x.cyc) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%b required=%b at edge %0d",
                     x.name, cyc, cur, x.val, x.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout pending=%0d required=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_state(input string nm);
    n_cmp++;
    if ({oSalida, oIndex, oBusy, oDone, oError} !== 10'd0) begin
      n_bad++;
      $display("FAIL %s got=%b required=%b", nm,
               {oSalida, oIndex, oBusy, oDone, oError}, 10'd0);
    end
  endtask

  logic [3:0] t1_sal [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000};
  logic [2:0] t1_idx [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    int s;
    int l;

    // Reset state
    idle(3);
    check_reset_state("reset_state");
    iReset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Forward run of 8 steps
    iSteps = 8'd8; iDir = 1'b0; s = cyc + 1;
    push("t1_busy", s, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      push("t1_step", s + 2 * (i + 1), t1_sal[i], t1_idx[i], 1'b1, 1'b0, 1'b0);
    push("t1_last_done", s + 16, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0);
    push("t1_idle", s + 17, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0);
    iStart = 1'b1; tick(); iStart = 1'b0;
    wait_drain("t1", 40);
    idle(3);

    // Preload 0111, reverse run of 3 steps
    l = cyc + 1;
    push("t2_load", l, 4'b0111, 3'd3, 1'b0, 1'b0, 1'b0);
    iLoad = 1'b1; iPattern = 4'b0111; tick(); iLoad = 1'b0;
    idle(2);
    iSteps = 8'd3; iDir = 1'b1; s = cyc + 1;
    push("t2_busy", s, 4'b0111, 3'd3, 1'b1, 1'b0, 1'b0);
    push("t2_step1", s + 2, 4'b0011, 3'd2, 1'b1, 1'b0, 1'b0);
    push("t2_step2", s + 4, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0);
    push("t2_done", s + 6, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0);
    push("t2_idle", s + 7, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0);
    iStart = 1'b1; tick(); iStart = 1'b0;
    wait_drain("t2", 20);
    idle(3);

    // Legal load, illegal load, legal load with sticky error
    l = cyc + 1;
    push("t3_load_0011", l, 4'b0011, 3'd2, 1'b0, 1'b0, 1'b0);
    iLoad = 1'b1; iPattern = 4'b0011; tick(); iLoad = 1'b0;
    idle(1);
    l = cyc + 1;
    push("t3_illegal_0101", l, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1);
    iLoad = 1'b1; iPattern = 4'b0101; tick(); iLoad = 1'b0;
    idle(1);
    l = cyc + 1;
    push("t3_load_1100", l, 4'b1100, 3'd6, 1'b0, 1'b0, 1'b1);
    iLoad = 1'b1; iPattern = 4'b1100; tick(); iLoad = 1'b0;
    wait_drain("t3", 10);
    idle(3);

    // Free run, 5-cycle hold, stop on a step-event cycle
    iSteps = 8'd0; iDir = 1'b0; s = cyc + 1;
    push("t4_busy", s, 4'b1100, 3'd6, 1'b1, 1'b0, 1'b1);
    push("t4_step1", s + 2, 4'b1000, 3'd7, 1'b1, 1'b0, 1'b1);
    push("t4_step2", s + 4, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b1);
    push("t4_after_hold", s + 12, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b1);
    push("t4_spacing", s + 14, 4'b0011, 3'd2, 1'b1, 1'b0, 1'b1);
    push("t4_stop", s + 16, 4'b0011, 3'd2, 1'b0, 1'b0, 1'b1);
    iStart = 1'b1; tick(); iStart = 1'b0;
    wait_until(s + 4);
    iHold = 1'b1; idle(5); iHold = 1'b0;
    wait_until(s + 15);
    iStop = 1'b1; tick(); iStop = 1'b0;
    wait_drain("t4", 30);
    idle(3);
    // Stop in IDLE must not change anything
    iStop = 1'b1; tick(); iStop = 1'b0;
    idle(3);

    // Load and start together: load only, stay idle
    l = cyc + 1;
    push("t5_load_start", l, 4'b1110, 3'd5, 1'b0, 1'b0, 1'b1);
    iLoad = 1'b1; iStart = 1'b1; iSteps = 8'd2; iPattern = 4'b1110;
    tick();
    iLoad = 1'b0; iStart = 1'b0;
    idle(4);
    // Two-step run aborted by reset after the first step
    iSteps = 8'd2; iDir = 1'b0; s = cyc + 1;
    push("t5_busy", s, 4'b1110, 3'd5, 1'b1, 1'b0, 1'b1);
    push("t5_step1", s + 2, 4'b1100, 3'd6, 1'b1, 1'b0, 1'b1);
    push("t5_reset", s + 3, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0);
    iStart = 1'b1; tick(); iStart = 1'b0;
    wait_until(s + 2);
    iReset = 1'b1; tick(); iReset = 1'b0;
    wait_drain("t5", 10);
    idle(5);
    check_reset_state("reset_abort_state");

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
